adder_share_ctrl: RTL and testbench

- Round-robin controller that shares one load/start/done sequential adder (WIDTH-bit operands A, B; result sum; completion flag done) among NREQ requesters.
- Arbitrates requests, latches the winner's operands, and sequences the adder through load, start and done.
- Returns the sum, or a timeout error, to the winning requester with a one-cycle response pulse.
- Sits between client logic and the adder instance.

---
 rtl/adder_share_ctrl.sv | 152 +++++++++++++++
 tb/tb_adder_share_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/adder_share_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// adder_share_ctrl : round-robin sharing of one load/start/done sequential
// adder among NREQ requesters, with timeout-to-error on a missing done.
// Rev 1.0
// ---------------------------------------------------------------------------
module adder_share_ctrl #(
    parameter int NREQ    = 4,
    parameter int WIDTH   = 4,
    parameter int TIMEOUT = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NREQ-1:0]           req_vec,
    input  logic [NREQ*WIDTH-1:0]     req_a,
    input  logic [NREQ*WIDTH-1:0]     req_b,
    output logic [NREQ-1:0]           gnt_vec,
    output logic                      rsp_valid,
    output logic [$clog2(NREQ)-1:0]   rsp_id,
    output logic [WIDTH-1:0]          rsp_sum,
    output logic                      rsp_err,
    output logic                      load,
    output logic                      start,
    output logic [WIDTH-1:0]          A,
    output logic [WIDTH-1:0]          B,
    input  logic [WIDTH-1:0]          sum,
    input  logic                      done
);

    localparam int IDW = $clog2(NREQ);
    localparam int CW  = $clog2(TIMEOUT) + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_START = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t           state, state_nxt;
    logic [IDW-1:0]   ptr;
    logic [IDW-1:0]   win;
    logic [IDW-1:0]   arb_idx;
    logic             arb_found;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [CW-1:0]    cnt;
    logic             timeout_hit;

    // Scan from the slot after the last winner, wrapping, so each
    // requester waits at most NREQ-1 operations.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = ptr;
        for (int i = 1; i <= NREQ; i++) begin
            if (!arb_found && req_vec[(int'(ptr) + i) % NREQ]) begin
                arb_found = 1'b1;
                arb_idx   = IDW'((int'(ptr) + i) % NREQ);
            end
        end
    end

    assign timeout_hit = (cnt == CW'(TIMEOUT - 1));
    assign rsp_valid   = (state == S_RESP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Adder controls decode straight from state so an async reset drops
    // load/start immediately.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        start     = 1'b0;
        A         = '0;
        B         = '0;
        case (state)
            S_IDLE: begin
                if (arb_found) state_nxt = S_LOAD;
            end
            S_LOAD: begin
                load      = 1'b1;
                A         = op_a;
                B         = op_b;
                state_nxt = S_START;
            end
            S_START: begin
                load  = 1'b1;
                start = 1'b1;
                A     = op_a;
                B     = op_b;
                if (done || timeout_hit) state_nxt = S_RESP;
            end
            S_RESP: begin
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr     <= IDW'(NREQ - 1);
            win     <= '0;
            gnt_vec <= '0;
            op_a    <= '0;
            op_b    <= '0;
            cnt     <= '0;
            rsp_id  <= '0;
            rsp_sum <= '0;
            rsp_err <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (arb_found) begin
                        gnt_vec <= NREQ'(1) << arb_idx;
                        ptr     <= arb_idx;
                        win     <= arb_idx;
                        op_a    <= req_a[arb_idx*WIDTH +: WIDTH];
                        op_b    <= req_b[arb_idx*WIDTH +: WIDTH];
                    end
                end
                S_START: begin
                    if (done) begin
                        rsp_sum <= sum;
                        rsp_err <= 1'b0;
                        rsp_id  <= win;
                        cnt     <= '0;
                    end else if (timeout_hit) begin
                        rsp_sum <= '0;
                        rsp_err <= 1'b1;
                        rsp_id  <= win;
                        cnt     <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_RESP: begin
                    gnt_vec <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_adder_share_ctrl.sv
`default_nettype none
// Directed self-checking bench for adder_share_ctrl with a behavioural
// sequential adder whose done latency and stuck-at modes are selectable.
module tb_adder_share_ctrl;

    localparam int NREQ    = 4;
    localparam int WIDTH   = 4;
    localparam int TIMEOUT = 32;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [NREQ-1:0]       req_vec = '0;
    logic [NREQ*WIDTH-1:0] req_a = '0;
    logic [NREQ*WIDTH-1:0] req_b = '0;
    logic [NREQ-1:0]       gnt_vec;
    logic                  rsp_valid;
    logic [1:0]            rsp_id;
    logic [WIDTH-1:0]      rsp_sum;
    logic                  rsp_err;
    logic                  load;
    logic                  start;
    logic [WIDTH-1:0]      A;
    logic [WIDTH-1:0]      B;
    logic [WIDTH-1:0]      sum;
    logic                  done;

    int checks = 0;
    int errors = 0;

    // 0: done dly cycles after start, 1: done stuck high, 2: done stuck low
    int       done_mode = 0;
    int       dly = 3;
    logic [7:0] acnt = '0;

    always #5 clk = ~clk;

    always_ff @(posedge clk) acnt <= start ? acnt + 8'd1 : 8'd0;
    assign done = (done_mode == 1) ? 1'b1 :
                  (done_mode == 2) ? 1'b0 : (start && (int'(acnt) >= dly));
    assign sum  = WIDTH'(A + B);

    adder_share_ctrl #(
        .NREQ    (NREQ),
        .WIDTH   (WIDTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_vec   (req_vec),
        .req_a     (req_a),
        .req_b     (req_b),
        .gnt_vec   (gnt_vec),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_err   (rsp_err),
        .load      (load),
        .start     (start),
        .A         (A),
        .B         (B),
        .sum       (sum),
        .done      (done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One isolated request; exp_cyc is the cycle of rsp_valid counted from
    // the granting edge (cycle 1 = first cycle after grant).
    task automatic run_single(input int idx, input int a, input int b,
                              input int exp_sum, input int exp_err, input int exp_cyc);
        int              cyc;
        bit              seen;
        logic [NREQ-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        req_a[idx*WIDTH +: WIDTH] = WIDTH'(a);
        req_b[idx*WIDTH +: WIDTH] = WIDTH'(b);
        req_vec = oh;
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
            if (cyc == 1) begin
                check("load_cycle1", {start, load}, 32'd1);
                req_a[idx*WIDTH +: WIDTH] = WIDTH'(~a);
                req_b[idx*WIDTH +: WIDTH] = WIDTH'(~b);
            end
            if (cyc == 2 && exp_cyc > 2) begin
                check("start_cycle2", {start, load}, 32'd3);
                check("op_a", A, a);
                check("op_b", B, b);
            end
            check("gnt_held", gnt_vec, oh);
            if (rsp_valid) begin
                seen    = 1'b1;
                req_vec = '0;
                check("rsp_id", rsp_id, idx);
                check("rsp_sum", rsp_sum, exp_sum);
                check("rsp_err", rsp_err, exp_err);
                check("rsp_cycle", cyc, exp_cyc);
                check("resp_ctrl_low", {start, load, A, B}, 32'd0);
            end
        end
        if (!seen) check("rsp_wait_expired", 0, 1);
        @(posedge clk);
        #1;
        check("gnt_release", gnt_vec, 0);
        check("rsp_one_pulse", rsp_valid, 0);
    endtask

    initial begin
        int cyc;
        int got;
        int gap;
        int exp_ids[5]  = '{0, 1, 2, 3, 0};
        int exp_sums[5] = '{2, 4, 6, 8, 2};

        #2;
        check("rst_async_outputs", {gnt_vec, rsp_valid, load, start, A, B}, 32'd0);
        do_reset();
        check("rst_state", {gnt_vec, rsp_valid, rsp_id, rsp_sum, rsp_err, load, start, A, B}, 32'd0);

        // single request, zero operands, modulo wrap
        done_mode = 0;
        dly = 3;
        run_single(0, 4, 5, 9, 0, 6);
        run_single(2, 0, 0, 0, 0, 6);
        run_single(3, 12, 11, 7, 0, 6);

        // fairness: all four requesting from a fresh pointer
        do_reset();
        dly = 1;
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*WIDTH +: WIDTH] = WIDTH'(i + 1);
            req_b[i*WIDTH +: WIDTH] = WIDTH'(i + 1);
        end
        req_vec = 4'b1111;
        cyc = 0;
        got = 0;
        gap = 0;
        while (got < 5 && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
            if (!load && !start) begin
                gap++;
            end else begin
                if (gap > 0 && got > 0) check("idle_gap", gap, 2);
                gap = 0;
            end
            if (rsp_valid) begin
                check("fair_id", rsp_id, exp_ids[got]);
                check("fair_sum", rsp_sum, exp_sums[got]);
                got++;
                if (got == 5) req_vec = '0;
            end
        end
        if (got < 5) check("fair_responses", got, 5);
        @(posedge clk);
        #1;

        // timeout, then a normal operation
        done_mode = 2;
        run_single(0, 1, 2, 0, 1, 2 + TIMEOUT);
        done_mode = 0;
        dly = 3;
        run_single(1, 2, 3, 5, 0, 6);

        // reset while the adder is started
        req_a[0 +: WIDTH] = 4'd3;
        req_b[0 +: WIDTH] = 4'd3;
        req_vec = 4'b0001;
        cyc = 0;
        while (!start && cyc < 10) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("midop_started", start, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("midop_rst_outputs", {gnt_vec, rsp_valid, load, start, A, B}, 32'd0);
        req_vec = 4'b0010;
        @(posedge clk);
        #1;
        check("midop_in_reset", {gnt_vec, rsp_valid, load, start}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_single(1, 5, 6, 11, 0, 6);

        // done stuck high from IDLE onward
        done_mode = 1;
        run_single(2, 2, 3, 5, 0, 3);
        done_mode = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
